triangle_bisect: RTL and testbench



---
 rtl/triangle_bisect_pkg.sv | 23 ++
 rtl/triangle_bisect_midpoint3d.sv | 34 +++
 rtl/triangle_bisect.sv | 54 +++++
 tb/tb_triangle_bisect.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/triangle_bisect_pkg.sv
// Shared geometry types for the triangle subdivision stage.
// Holds the coordinate width and the packed point/triangle structs that every
// block in this stage passes around. Field order is MSB-first, so a
// Triangle3D is {p, q, r} and each Point3D is {x, y, z}.
package triangle_bisect_pkg;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } Point3D;

  typedef struct packed {
    Point3D p;
    Point3D q;
    Point3D r;
  } Triangle3D;

  localparam int TRI_W = $bits(Triangle3D);

endpackage

// File: rtl/triangle_bisect_midpoint3d.sv
// midpoint3d: purely combinational midpoint of two 3D points.
// Ports:
//   i_a, i_b : the two endpoints (signed 16-bit coordinates)
//   o_mid    : per-coordinate floor((a + b) / 2)
// Each sum is formed one bit wider so that no pair of 16-bit inputs can
// overflow; dropping the LSB of that sum is the floor of the average, and the
// result always fits back into 16 bits.
module midpoint3d
  import triangle_bisect_pkg::*;
(
  input  Point3D i_a,
  input  Point3D i_b,
  output Point3D o_mid
);

  logic signed [COORD_W:0] w_sumX;
  logic signed [COORD_W:0] w_sumY;
  logic signed [COORD_W:0] w_sumZ;

  // Sign-extend both operands by one bit before adding so the 17-bit sum is exact.
  assign w_sumX = {i_a.x[COORD_W-1], i_a.x} + {i_b.x[COORD_W-1], i_b.x};
  assign w_sumY = {i_a.y[COORD_W-1], i_a.y} + {i_b.y[COORD_W-1], i_b.y};
  assign w_sumZ = {i_a.z[COORD_W-1], i_a.z} + {i_b.z[COORD_W-1], i_b.z};

  // Halve each exact sum; the arithmetic shift rounds toward minus infinity,
  // and the top bit of the shifted value is always redundant sign.
  always_comb begin
    o_mid   = '0;
    o_mid.x = COORD_W'(w_sumX >>> 1);
    o_mid.y = COORD_W'(w_sumY >>> 1);
    o_mid.z = COORD_W'(w_sumZ >>> 1);
  end

endmodule

// File: rtl/triangle_bisect.sv
// triangle_bisect: splits a triangle along edge PQ and registers one half.
// Upstream has already rotated the vertices so PQ is the longest edge, so this
// block always bisects PQ at its midpoint m. Driving the same triangle for two
// cycles with tri_select = 0 then 1 produces both halves.
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : asynchronous reset, ACTIVE HIGH despite its name
//   tri_in     : input triangle {p, q, r}
//   tri_select : 0 -> output {p, m, r}; 1 -> output {m, q, r}
//   tri_out    : registered half-triangle, one cycle after the inputs
module triangle_bisect
  import triangle_bisect_pkg::*;
(
  input  logic      clk,
  input  logic      n_rst,
  input  Triangle3D tri_in,
  input  logic      tri_select,
  output Triangle3D tri_out
);

  Point3D    w_mid;
  Triangle3D w_nextTri;
  Triangle3D r_triOut;

  midpoint3d uMidpoint (
    .i_a   (tri_in.p),
    .i_b   (tri_in.q),
    .o_mid (w_mid)
  );

  // Select which half to keep: the midpoint replaces q for the first half and
  // p for the second. Vertex r is shared by both halves and passes straight through.
  always_comb begin
    w_nextTri = tri_in;
    if (tri_select) begin
      w_nextTri.p = w_mid;
    end else begin
      w_nextTri.q = w_mid;
    end
  end

  // Single output register. There is no handshake, so a new half is captured
  // every cycle; reset clears it immediately and nothing else is held.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_triOut <= '0;
    end else begin
      r_triOut <= w_nextTri;
    end
  end

  assign tri_out = r_triOut;

endmodule

// File: tb/tb_triangle_bisect.sv
// Self-checking bench for triangle_bisect.
// Inputs are driven on the falling edge; the expected half is pushed to a
// scoreboard queue at the same moment and popped/compared 1 ns after the
// following rising edge.
module tb_triangle_bisect;
  import triangle_bisect_pkg::*;

  logic      clk;
  logic      nRst;
  Triangle3D triIn;
  logic      triSelect;
  Triangle3D triOut;

  Triangle3D expQ[$];
  int        checkCount;
  int        errorCount;

  triangle_bisect dut (
    .clk        (clk),
    .n_rst      (nRst),
    .tri_in     (triIn),
    .tri_select (triSelect),
    .tri_out    (triOut)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic Point3D mkPt(input int x, input int y, input int z);
    Point3D pt;
    pt.x = 16'(x);
    pt.y = 16'(y);
    pt.z = 16'(z);
    return pt;
  endfunction

  function automatic Triangle3D mkTri(input Point3D p, input Point3D q, input Point3D r);
    Triangle3D t;
    t.p = p;
    t.q = q;
    t.r = r;
    return t;
  endfunction

  // Reference: floor of the average using 32-bit integer arithmetic.
  function automatic logic signed [15:0] floorAvg(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
    int s;
    int f;
    s = int'(a) + int'(b);
    f = (s - ((s % 2 + 2) % 2)) / 2;
    return 16'(f);
  endfunction

  function automatic Triangle3D modelHalf(input Triangle3D t, input logic sel);
    Point3D    m;
    Triangle3D e;
    m.x = floorAvg(t.p.x, t.q.x);
    m.y = floorAvg(t.p.y, t.q.y);
    m.z = floorAvg(t.p.z, t.q.z);
    e = t;
    if (sel) e.p = m;
    else     e.q = m;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input Triangle3D observed, input Triangle3D expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one triangle for one cycle, queue its expected half, then compare
  // after the capturing edge.
  task automatic applyStimulus(input string tag, input Triangle3D t, input logic sel,
                               input Triangle3D expected);
    Triangle3D exp;
    @(negedge clk);
    triIn     = t;
    triSelect = sel;
    expQ.push_back(expected);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_emptyq"}, triOut, ~triOut);
    end else begin
      exp = expQ.pop_front();
      checkOutput(tag, triOut, exp);
    end
  endtask

  initial begin
    Triangle3D tBasic;
    Triangle3D tExt;
    Triangle3D tMax;
    Triangle3D tMin;
    Triangle3D tRand;
    Point3D    mBasic;
    Point3D    r0;

    checkCount = 0;
    errorCount = 0;

    // Reset held with arbitrary input: output must stay zero through edges.
    nRst      = 1'b1;
    triIn     = {$urandom, $urandom, $urandom, $urandom, $urandom};
    triSelect = 1'b1;
    #1;
    checkOutput("reset_async", triOut, '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", triOut, '0);

    @(negedge clk);
    nRst = 1'b0;

    // Directed: hand-computed halves.
    r0     = mkPt(-3, 6, -8);
    mBasic = mkPt(3, 14, -12);
    tBasic = mkTri(mkPt(-10, -3, -23), mkPt(16, 32, 0), r0);
    applyStimulus("basic_sel0", tBasic, 1'b0, mkTri(tBasic.p, mBasic, r0));
    applyStimulus("basic_sel1", tBasic, 1'b1, mkTri(mBasic, tBasic.q, r0));

    tExt = mkTri(mkPt(-16383, -16383, -16383), mkPt(16383, 16383, 16383),
                 mkPt(-16383, 16383, -16383));
    applyStimulus("extreme_sel0", tExt, 1'b0, mkTri(tExt.p, mkPt(0, 0, 0), tExt.r));
    applyStimulus("extreme_sel1", tExt, 1'b1, mkTri(mkPt(0, 0, 0), tExt.q, tExt.r));

    tMax = mkTri(mkPt(32767, 32767, 32767), mkPt(32767, 32767, 32767), mkPt(1, -1, 7));
    applyStimulus("max_sel0", tMax, 1'b0, tMax);
    applyStimulus("max_sel1", tMax, 1'b1, tMax);

    tMin = mkTri(mkPt(-32768, -32768, -32768), mkPt(-32768, -32768, -32768), mkPt(5, 0, -5));
    applyStimulus("min_sel0", tMin, 1'b0, tMin);
    applyStimulus("min_sel1", tMin, 1'b1, tMin);

    // Mixed extremes where the exact sum needs the 17th bit.
    tRand = mkTri(mkPt(32767, -32768, 32767), mkPt(32766, -32767, -32768), mkPt(0, 0, 0));
    applyStimulus("carry_sel0", tRand, 1'b0,
                  mkTri(tRand.p, mkPt(32766, -32768, -1), tRand.r));

    // Reset mid-sequence: output clears at once without a clock edge.
    applyStimulus("premid_sel0", tBasic, 1'b0, mkTri(tBasic.p, mBasic, r0));
    @(negedge clk);
    nRst = 1'b1;
    #1;
    checkOutput("reset_midseq", triOut, '0);
    @(negedge clk);
    nRst = 1'b0;
    applyStimulus("post_reset_sel1", tBasic, 1'b1, mkTri(mBasic, tBasic.q, r0));

    // Random sweep, new triangle every cycle with alternating select.
    for (int i = 0; i < 1000; i++) begin
      tRand = {$urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus("sweep", tRand, i[0], modelHalf(tRand, i[0]));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
